// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad column scanner.
//   scan_state_t : scanner FSM states
//   ROWS_IDLE    : row bus value with no key pressed (active-low, pulled up)
//   N_ROWS/N_COLS: matrix geometry
//   key_code_t   : row*4 + col key code
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;

    localparam logic [N_ROWS-1:0] ROWS_IDLE = 4'hF;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        S_DRIVE,
        S_DEBOUNCE,
        S_REPORT,
        S_RELEASE
    } scan_state_t;

endpackage

// File: rtl/keypad_row_prienc.sv
// keypad_row_prienc: combinational lowest-zero priority encoder for the
// active-low row bus.
//   rows_n      : row lines, 0 = pressed
//   row_idx     : index of the lowest-numbered pressed row (0 when none)
//   any_pressed : at least one row reads 0
module keypad_row_prienc
    import keypad_pkg::*;
(
    input  logic [N_ROWS-1:0] rows_n,
    output logic [1:0]        row_idx,
    output logic              any_pressed
);

    always_comb begin
        row_idx     = 2'd0;
        any_pressed = ~&rows_n;
        // Walk from the top down so the lowest pressed row is written last.
        for (int i = N_ROWS - 1; i >= 0; i--) begin
            if (!rows_n[i]) row_idx = i[1:0];
        end
    end

endmodule

// File: rtl/keypad_col_scanner.sv
// keypad_col_scanner: strobes the keypad columns one at a time (active low),
// debounces a press on the driven column, reports one key code per press and
// waits for a debounced release before scanning again.
//   clk, rst_n   : clock, synchronous active-low reset
//   filas_in     : row lines, active-low
//   columnas_out : one-hot-low column drive
//   key_valid    : one-cycle pulse when key_code is updated
//   key_code     : row*4 + col of the last accepted key
//   key_held     : high from key_valid until the release is debounced
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_ROWS-1:0] filas_in,
    output logic [N_COLS-1:0] columnas_out,
    output logic              key_valid,
    output key_code_t         key_code,
    output logic              key_held
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int KW = $clog2(STABLE_SAMPLES + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    // Compare against N-1 so the counter never has to hold N+1.
    localparam logic [KW-1:0] STABLE_LAST = KW'(STABLE_SAMPLES - 1);

    scan_state_t       state, state_nxt;
    logic [1:0]        col_idx, col_nxt;
    logic [SW-1:0]     settle_cnt, settle_nxt;
    logic [KW-1:0]     stab_cnt, stab_nxt;
    logic [KW-1:0]     rel_cnt, rel_nxt;
    logic [N_ROWS-1:0] ref_rows, ref_nxt;
    logic              key_valid_nxt, key_held_nxt;
    key_code_t         key_code_nxt;
    logic [N_COLS-1:0] cols_nxt;

    logic [1:0]        ref_row;
    logic              ref_any;

    keypad_row_prienc u_prienc (
        .rows_n      (ref_rows),
        .row_idx     (ref_row),
        .any_pressed (ref_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_DRIVE;
            col_idx      <= 2'd0;
            settle_cnt   <= '0;
            stab_cnt     <= '0;
            rel_cnt      <= '0;
            ref_rows     <= ROWS_IDLE;
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_held     <= 1'b0;
            columnas_out <= 4'b1110;
        end else begin
            state        <= state_nxt;
            col_idx      <= col_nxt;
            settle_cnt   <= settle_nxt;
            stab_cnt     <= stab_nxt;
            rel_cnt      <= rel_nxt;
            ref_rows     <= ref_nxt;
            key_valid    <= key_valid_nxt;
            key_code     <= key_code_nxt;
            key_held     <= key_held_nxt;
            columnas_out <= cols_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        col_nxt       = col_idx;
        settle_nxt    = settle_cnt;
        stab_nxt      = stab_cnt;
        rel_nxt       = rel_cnt;
        ref_nxt       = ref_rows;
        key_valid_nxt = 1'b0;
        key_code_nxt  = key_code;
        key_held_nxt  = key_held;

        unique case (state)
            S_DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_nxt = '0;
                    if (filas_in == ROWS_IDLE) begin
                        col_nxt = col_idx + 2'd1;
                    end else begin
                        ref_nxt   = filas_in;
                        stab_nxt  = KW'(1);
                        state_nxt = S_DEBOUNCE;
                    end
                end else begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end

            S_DEBOUNCE: begin
                if (filas_in == ROWS_IDLE) begin
                    // Bounce back to idle: drop the candidate, keep scanning.
                    stab_nxt   = '0;
                    col_nxt    = col_idx + 2'd1;
                    settle_nxt = '0;
                    state_nxt  = S_DRIVE;
                end else if (filas_in == ref_rows) begin
                    if (stab_cnt == STABLE_LAST) begin
                        stab_nxt  = '0;
                        state_nxt = S_REPORT;
                    end else begin
                        stab_nxt = stab_cnt + KW'(1);
                    end
                end else begin
                    // Row pattern changed while still pressed: restart on it.
                    ref_nxt  = filas_in;
                    stab_nxt = KW'(1);
                end
            end

            S_REPORT: begin
                rel_nxt   = '0;
                state_nxt = S_RELEASE;
                if (ref_any) begin
                    key_valid_nxt = 1'b1;
                    key_held_nxt  = 1'b1;
                    key_code_nxt  = {ref_row, col_idx};
                end
            end

            S_RELEASE: begin
                if (filas_in == ROWS_IDLE) begin
                    if (rel_cnt == STABLE_LAST) begin
                        rel_nxt      = '0;
                        key_held_nxt = 1'b0;
                        col_nxt      = col_idx + 2'd1;
                        settle_nxt   = '0;
                        state_nxt    = S_DRIVE;
                    end else begin
                        rel_nxt = rel_cnt + KW'(1);
                    end
                end else begin
                    rel_nxt = '0;
                end
            end

            default: state_nxt = S_DRIVE;
        endcase

        // Column drive is registered alongside col_idx so both move together.
        cols_nxt = ~(4'b0001 << col_nxt);
    end

endmodule
